pipelined_addsub: RTL and testbench

- Parametrised N-bit adder/subtractor split into STAGES carry-chained slices. Each slice adds one N/STAGES-bit chunk per clock.
- Supports add, subtract, add-with-carry and subtract-with-borrow.
- Produces carry, signed-overflow and zero flags.
- Valid/ready handshake on both sides. Used as the shared arithmetic unit feeding ALU/datapath blocks, where the clock rate rules out a single-cycle N-bit carry chain.

---
 rtl/pipelined_addsub_pkg.sv | 16 +
 rtl/addsub_slice.sv | 27 ++
 rtl/pipelined_addsub.sv | 157 +++++++++++++++
 tb/tb_pipelined_addsub.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_addsub_pkg.sv
// Shared types and elaboration helpers for the pipelined adder/subtractor.
package pipelined_addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBB = 2'b11
    } op_t;

    // True when the operand width splits into equal-width slices.
    function automatic bit stages_divide_width(input int width, input int stages);
        return (stages > 0) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational W-bit slice of the carry chain. Also exposes the carry into
// the slice MSB so the top slice can form the signed-overflow flag.
module addsub_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb
);

    if (W == 1) begin : g_bit
        assign c_msb     = cin;
        assign {cout, s} = 2'(a) + 2'(b) + 2'(cin);
    end else begin : g_wide
        logic [W-1:0] low;

        // Lower W-1 bits first; the top bit of this sum is the carry into the MSB.
        assign low            = W'(a[W-2:0]) + W'(b[W-2:0]) + W'(cin);
        assign c_msb          = low[W-1];
        assign s[W-2:0]       = low[W-2:0];
        assign {cout, s[W-1]} = 2'(a[W-1]) + 2'(b[W-1]) + 2'(c_msb);
    end

endmodule

// File: rtl/pipelined_addsub.sv
// N-bit adder/subtractor split into STAGES carry-chained slices. Each stage
// consumes one chunk of the operands and forwards the still-unused upper
// chunks together with the sum chunks produced so far. A single global
// enable (advance) moves or holds the whole pipeline.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic         cin,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    localparam int W = N / STAGES;

    if (!stages_divide_width(N, STAGES)) begin : g_bad_cfg
        $error("pipelined_addsub: STAGES must divide N exactly");
    end

    logic         advance;
    logic [N-1:0] b_adj;
    logic         carry0;

    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;

    // Operand B conditioning and initial carry, chosen by the operation.
    always_comb begin
        b_adj  = b;
        carry0 = 1'b0;
        case (op_t'(op))
            OP_ADD: begin b_adj = b;  carry0 = 1'b0; end
            OP_SUB: begin b_adj = ~b; carry0 = 1'b1; end
            OP_ADC: begin b_adj = b;  carry0 = cin;  end
            OP_SBB: begin b_adj = ~b; carry0 = cin;  end
            default: begin b_adj = b; carry0 = 1'b0; end
        endcase
    end

    // Stage k payload layout: {a_upper, b_upper, sum_lower}. The upper operand
    // fields shrink by W per stage while the sum field grows by W, so every
    // stored bit is consumed downstream.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LW = (k + 1) * W;
        localparam int HW = N - LW;
        localparam int DW = 2 * HW + LW;

        logic [W-1:0]  sl_a;
        logic [W-1:0]  sl_b;
        logic [W-1:0]  sl_s;
        logic          sl_cin;
        logic          sl_cout;
        logic          valid_in;
        logic [DW-1:0] d_next;

        if (k == 0) begin : g_entry
            assign sl_a     = a[W-1:0];
            assign sl_b     = b_adj[W-1:0];
            assign sl_cin   = carry0;
            assign valid_in = in_valid;
            if (HW > 0) begin : g_fwd
                assign d_next = {a[N-1:W], b_adj[N-1:W], sl_s};
            end else begin : g_end
                assign d_next = sl_s;
            end
        end else begin : g_chain
            localparam int PLW = k * W;
            localparam int PHW = N - PLW;

            logic [PHW-1:0] pa;
            logic [PHW-1:0] pb;
            logic [PLW-1:0] ps;

            assign {pa, pb, ps} = g_stage[k-1].g_hold.data_q;
            assign sl_a         = pa[W-1:0];
            assign sl_b         = pb[W-1:0];
            assign sl_cin       = g_stage[k-1].g_hold.carry_q;
            assign valid_in     = g_stage[k-1].g_hold.valid_q;
            if (HW > 0) begin : g_fwd
                assign d_next = {pa[PHW-1:W], pb[PHW-1:W], sl_s, ps};
            end else begin : g_end
                assign d_next = {sl_s, ps};
            end
        end

        if (k < STAGES - 1) begin : g_hold
            logic          valid_q;
            logic          carry_q;
            logic [DW-1:0] data_q;
            logic          c_msb_unused;

            addsub_slice #(.W(W)) u_slice (
                .a    (sl_a),
                .b    (sl_b),
                .cin  (sl_cin),
                .s    (sl_s),
                .cout (sl_cout),
                .c_msb(c_msb_unused)
            );

            // Intermediate stage: capture chunk sum, carry and remaining operands.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    carry_q <= 1'b0;
                    data_q  <= '0;
                end else if (advance) begin
                    valid_q <= valid_in;
                    carry_q <= sl_cout;
                    data_q  <= d_next;
                end
            end
        end else begin : g_out
            logic c_msb;

            addsub_slice #(.W(W)) u_slice (
                .a    (sl_a),
                .b    (sl_b),
                .cin  (sl_cin),
                .s    (sl_s),
                .cout (sl_cout),
                .c_msb(c_msb)
            );

            // Final stage: result and flags, forced to zero for bubbles.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    out_valid <= 1'b0;
                    s         <= '0;
                    cout      <= 1'b0;
                    ovf       <= 1'b0;
                    zero      <= 1'b0;
                end else if (advance) begin
                    out_valid <= valid_in;
                    s         <= valid_in ? d_next : '0;
                    cout      <= valid_in & sl_cout;
                    ovf       <= valid_in & (c_msb ^ sl_cout);
                    zero      <= valid_in & (d_next == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: an 8-bit/4-stage and a 32-bit/1-stage instance
// share stimulus; one is selected at a time and checked against an arithmetic
// reference model through an in-order scoreboard.
module tb_pipelined_addsub;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic        cin;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    logic        in_ready8, out_valid8, cout8, ovf8, zero8;
    logic [7:0]  s8;
    logic        in_ready32, out_valid32, cout32, ovf32, zero32;
    logic [31:0] s32;

    logic        sel;
    logic        ir, ov, co, of, zr;
    logic [31:0] so;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_ret = 0;
    int stg;
    int nbits;
    bit lat_en;

    typedef struct {
        logic [34:0] v;
        int          acc;
        bit          seen;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    pipelined_addsub #(.N(8), .STAGES(4)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
        .op(op), .cin(cin), .a(a[7:0]), .b(b[7:0]),
        .out_valid(out_valid8), .out_ready(out_ready),
        .s(s8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    pipelined_addsub #(.N(32), .STAGES(1)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
        .op(op), .cin(cin), .a(a), .b(b),
        .out_valid(out_valid32), .out_ready(out_ready),
        .s(s32), .cout(cout32), .ovf(ovf32), .zero(zero32)
    );

    always_comb begin
        if (sel) begin
            ir = in_ready32; ov = out_valid32; so = s32;
            co = cout32; of = ovf32; zr = zero32;
        end else begin
            ir = in_ready8; ov = out_valid8; so = {24'd0, s8};
            co = cout8; of = ovf8; zr = zero8;
        end
    end

    // Reference: plain modular arithmetic, overflow from operand/result signs.
    function automatic logic [34:0] model(int n, logic [1:0] o, logic c,
                                          logic [31:0] x, logic [31:0] y);
        logic [63:0] mask, xa, yb, sum, res;
        logic cy, co_m, ov_m, sx, sy, sr;
        mask = (64'd1 << n) - 64'd1;
        xa   = {32'd0, x} & mask;
        case (o)
            2'b00:   begin yb = {32'd0, y};  cy = 1'b0; end
            2'b01:   begin yb = {32'd0, ~y}; cy = 1'b1; end
            2'b10:   begin yb = {32'd0, y};  cy = c;    end
            default: begin yb = {32'd0, ~y}; cy = c;    end
        endcase
        yb   = yb & mask;
        sum  = xa + yb + {63'd0, cy};
        res  = sum & mask;
        co_m = sum[n];
        sx   = xa[n-1];
        sy   = yb[n-1];
        sr   = res[n-1];
        ov_m = (sx == sy) && (sr != sx);
        return {co_m, ov_m, (res == 64'd0), res[31:0]};
    endfunction

    task automatic chk(string tag, logic [34:0] got, logic [34:0] exp_v);
        n_cmp++;
        assert (got === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp_v);
        end
    endtask

    task automatic rand_ops();
        op  = 2'($urandom_range(0, 3));
        cin = 1'($urandom_range(0, 1));
        a   = $urandom;
        b   = ($urandom_range(0, 7) == 0) ? a : $urandom;
    endtask

    // One clock: check visible output against scoreboard, record acceptance.
    task automatic step(output bit acc);
        exp_t e;
        #1;
        acc = in_valid && ir;
        if (ov) begin
            chk("out_expected", 35'(q.size() > 0), 35'd1);
            if (q.size() > 0) begin
                chk("result", {co, of, zr, so}, q[0].v);
                if (!q[0].seen && lat_en)
                    chk("latency", 35'(cyc - q[0].acc), 35'(stg));
                q[0].seen = 1'b1;
                if (out_ready) begin
                    void'(q.pop_front());
                    n_ret++;
                end
            end
        end
        if (acc) begin
            e.v    = model(nbits, op, cin, a, b);
            e.acc  = cyc;
            e.seen = 1'b0;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        bit acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < stg + 3; k++) step(acc);
        chk("drain_empty", 35'(q.size()), 35'd0);
    endtask

    task automatic reset_test();
        bit acc;
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_out_valid", 35'(ov), 35'd0);
        chk("rst_result", {co, of, zr, so}, 35'd0);
        chk("rst_in_ready", 35'(ir), 35'd1);
        q.delete();
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        lat_en    = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        rand_ops();
        step(acc);
        chk("rst_accept", 35'(acc), 35'd1);
        drain();
    endtask

    task automatic directed(string tag, logic [1:0] o, logic c, logic [7:0] x,
                            logic [7:0] y, logic [34:0] exp_v);
        bit acc;
        lat_en    = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op = o; cin = c; a = {24'd0, x}; b = {24'd0, y};
        step(acc);
        chk({tag, "_accept"}, 35'(acc), 35'd1);
        in_valid = 1'b0;
        op = ~o; cin = ~c; a = ~a; b = ~b;
        for (int k = 0; k < 10 && !ov; k++) step(acc);
        chk({tag, "_seen"}, 35'(ov), 35'd1);
        chk({tag, "_value"}, {co, of, zr, so}, exp_v);
        step(acc);
    endtask

    task automatic stall_stream();
        bit acc = 1'b0;
        int j   = 0;
        int n0  = n_ret;
        lat_en = 1'b0;
        for (int i = 0; i < 40 && (j < 8 || q.size() > 0); i++) begin
            out_ready = !(i >= 5 && i <= 7);
            in_valid  = (j < 8);
            if (i == 0 || acc) rand_ops();
            #1;
            chk("stall_in_ready", 35'(ir), 35'(!(i >= 5 && i <= 7)));
            step(acc);
            if (acc) j++;
        end
        chk("stall_retired", 35'(n_ret - n0), 35'd8);
        chk("stall_empty", 35'(q.size()), 35'd0);
    endtask

    task automatic full_stream();
        bit acc;
        lat_en    = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rand_ops();
            if (i >= stg) chk("thru_out_valid", 35'(ov), 35'd1);
            step(acc);
            chk("thru_accept", 35'(acc), 35'd1);
        end
        drain();
    endtask

    task automatic random_stream();
        bit acc = 1'b0;
        lat_en   = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || acc) begin
                in_valid = 1'($urandom_range(0, 1));
                rand_ops();
            end
            step(acc);
        end
        drain();
    endtask

    task automatic mid_stream_reset();
        bit acc;
        lat_en    = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            step(acc);
        end
        reset_test();
    endtask

    initial begin
        sel = 1'b0; stg = 4; nbits = 8; lat_en = 1'b1;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = 2'b00; cin = 1'b0; a = '0; b = '0;
        @(posedge clk);
        #1;
        chk("init_out_valid", 35'(ov), 35'd0);
        chk("init_result", {co, of, zr, so}, 35'd0);
        chk("init_in_ready", 35'(ir), 35'd1);

        reset_test();
        directed("add_7f_01", 2'b00, 1'b0, 8'h7F, 8'h01, {1'b0, 1'b1, 1'b0, 32'h80});
        directed("sub_05_05", 2'b01, 1'b0, 8'h05, 8'h05, {1'b1, 1'b0, 1'b1, 32'h00});
        directed("sub_03_05", 2'b01, 1'b0, 8'h03, 8'h05, {1'b0, 1'b0, 1'b0, 32'hFE});
        directed("adc_ff_00", 2'b10, 1'b1, 8'hFF, 8'h00, {1'b1, 1'b0, 1'b1, 32'h00});
        directed("sbb_80_01", 2'b11, 1'b1, 8'h80, 8'h01, {1'b1, 1'b1, 1'b0, 32'h7F});
        directed("sbb_00_00", 2'b11, 1'b0, 8'h00, 8'h00, {1'b0, 1'b0, 1'b0, 32'hFF});
        directed("add_ff_01", 2'b00, 1'b0, 8'hFF, 8'h01, {1'b1, 1'b0, 1'b1, 32'h00});
        stall_stream();
        full_stream();
        random_stream();
        mid_stream_reset();

        sel = 1'b1; stg = 1; nbits = 32;
        reset_test();
        stall_stream();
        full_stream();
        random_stream();
        mid_stream_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
